marker_tracker: RTL and testbench



---
 rtl/tracker_pkg.sv | 28 ++
 rtl/marker_run_filter.sv | 58 +++++
 rtl/marker_tracker.sv | 163 ++++++++++++++++
 tb/tb_marker_tracker.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// Shared types for the colour-marker tracker.
// Coordinates, points, FSM states and the colour test.
package tracker_pkg;

  typedef logic [10:0] coord_t;
  typedef coord_t [1:0] point_t;

  localparam coord_t NOT_FOUND = 11'd2023;
  localparam point_t NOWHERE = {NOT_FOUND, NOT_FOUND};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  function automatic logic colour_hit(
    input logic [7:0] r,
    input logic [7:0] g,
    input logic [7:0] b,
    input logic [7:0] r_min,
    input logic [7:0] g_max,
    input logic [7:0] b_max
  );
    return (r >= r_min) && (g <= g_max) && (b <= b_max);
  endfunction

endpackage

// File: rtl/marker_run_filter.sv
// Horizontal run filter: a pixel qualifies only once it ends
// a run of at least RUN_MIN adjacent matches on one row.
module marker_run_filter
  import tracker_pkg::*;
#(
  parameter int RUN_MIN = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_valid,
  input  logic   i_match,
  input  coord_t i_x,
  input  coord_t i_y,
  output logic   o_qual
);

  localparam int CW = $clog2(RUN_MIN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_MIN);
  localparam logic [CW-1:0] RUN_ONE = CW'(1);

  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_nxt;
  coord_t prev_x;
  coord_t prev_y;
  logic adjacent;

  assign adjacent = (i_y == prev_y) && (i_x == prev_x + 11'd1);

  always_comb begin
    run_nxt = run_cnt;
    if (i_valid) begin
      if (!i_match) begin
        run_nxt = '0;
      end else if (adjacent) begin
        run_nxt = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + RUN_ONE;
      end else begin
        run_nxt = RUN_ONE;
      end
    end
  end

  assign o_qual = i_valid && i_match && (run_nxt >= RUN_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      run_cnt <= '0;
      prev_x  <= '1;
      prev_y  <= '1;
    end else begin
      run_cnt <= run_nxt;
      if (i_valid && i_match) begin
        prev_x <= i_x;
        prev_y <= i_y;
      end
    end
  end

endmodule

// File: rtl/marker_tracker.sv
// Per-frame marker tracker: finds the extreme qualified pixels
// of each frame and publishes them with a one-cycle strobe.
module marker_tracker
  import tracker_pkg::*;
#(
  parameter logic [7:0] R_MIN      = 8'd160,
  parameter logic [7:0] G_MAX      = 8'd90,
  parameter logic [7:0] B_MAX      = 8'd90,
  parameter int         RUN_MIN    = 4,
  parameter int         MIN_PIXELS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_valid,
  input  coord_t      i_x,
  input  coord_t      i_y,
  input  logic [7:0]  i_rgb [2:0],
  input  logic        i_frame_end,
  output coord_t      o_left [1:0],
  output coord_t      o_right [1:0],
  output coord_t      o_up [1:0],
  output coord_t      o_down [1:0],
  output logic [19:0] o_count,
  output logic        o_valid
);

  localparam logic [19:0] MIN_CNT = 20'(MIN_PIXELS);
  localparam logic [19:0] CNT_MAX = 20'hFFFFF;

  state_t state;

  logic   s1_valid;
  logic   s1_match;
  logic   s1_fe;
  coord_t s1_x;
  coord_t s1_y;
  logic   qual;

  point_t acc_l, acc_r, acc_u, acc_d;
  point_t l_n, r_n, u_n, d_n;
  logic [19:0] cnt, cnt_n;
  point_t pub_l, pub_r, pub_u, pub_d;
  point_t pix;
  logic   clr;
  logic   take;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_match <= 1'b0;
      s1_fe    <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= i_valid;
      s1_match <= i_valid &&
        colour_hit(i_rgb[0], i_rgb[1], i_rgb[2], R_MIN, G_MAX, B_MAX);
      s1_fe    <= i_frame_end;
      s1_x     <= i_x;
      s1_y     <= i_y;
    end
  end

  marker_run_filter #(
    .RUN_MIN (RUN_MIN)
  ) u_run (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (s1_valid),
    .i_match (s1_match),
    .i_x     (s1_x),
    .i_y     (s1_y),
    .o_qual  (qual)
  );

  assign pix = {s1_y, s1_x};

  // Publish restarts the accumulators but still takes the next frame's pixel.
  always_comb begin
    clr   = (state != S_ACCUM);
    take  = qual && ((state == S_ACCUM) ||
                     ((state == S_PUBLISH) && i_enable));
    l_n   = clr ? NOWHERE : acc_l;
    r_n   = clr ? NOWHERE : acc_r;
    u_n   = clr ? NOWHERE : acc_u;
    d_n   = clr ? NOWHERE : acc_d;
    cnt_n = clr ? '0 : cnt;
    if (take) begin
      if (cnt_n == '0) begin
        l_n = pix;
        r_n = pix;
        u_n = pix;
        d_n = pix;
      end else begin
        if (pix[0] < l_n[0]) l_n = pix;
        if (pix[0] > r_n[0]) r_n = pix;
        if (pix[1] < u_n[1]) u_n = pix;
        if (pix[1] > d_n[1]) d_n = pix;
      end
      if (cnt_n != CNT_MAX) cnt_n = cnt_n + 20'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= S_IDLE;
      acc_l   <= NOWHERE;
      acc_r   <= NOWHERE;
      acc_u   <= NOWHERE;
      acc_d   <= NOWHERE;
      cnt     <= '0;
      pub_l   <= NOWHERE;
      pub_r   <= NOWHERE;
      pub_u   <= NOWHERE;
      pub_d   <= NOWHERE;
      o_count <= '0;
      o_valid <= 1'b0;
    end else begin
      acc_l   <= l_n;
      acc_r   <= r_n;
      acc_u   <= u_n;
      acc_d   <= d_n;
      cnt     <= cnt_n;
      o_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (s1_fe && i_enable) state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (s1_fe) state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          state   <= i_enable ? S_ACCUM : S_IDLE;
          o_valid <= 1'b1;
          o_count <= cnt;
          if (cnt >= MIN_CNT) begin
            pub_l <= acc_l;
            pub_r <= acc_r;
            pub_u <= acc_u;
            pub_d <= acc_d;
          end else begin
            pub_l <= NOWHERE;
            pub_r <= NOWHERE;
            pub_u <= NOWHERE;
            pub_d <= NOWHERE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_left[0]  = pub_l[0];
  assign o_left[1]  = pub_l[1];
  assign o_right[0] = pub_r[0];
  assign o_right[1] = pub_r[1];
  assign o_up[0]    = pub_u[0];
  assign o_up[1]    = pub_u[1];
  assign o_down[0]  = pub_d[0];
  assign o_down[1]  = pub_d[1];

endmodule

// File: tb/tb_marker_tracker.sv
// Scoreboard bench for marker_tracker: expected frames are queued
// at frame end and compared when o_valid strobes.
module tb_marker_tracker;
  import tracker_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_enable;
  logic        i_valid;
  coord_t      i_x;
  coord_t      i_y;
  logic [7:0]  i_rgb [2:0];
  logic        i_frame_end;
  coord_t      o_left [1:0];
  coord_t      o_right [1:0];
  coord_t      o_up [1:0];
  coord_t      o_down [1:0];
  logic [19:0] o_count;
  logic        o_valid;

  marker_tracker dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_x         (i_x),
    .i_y         (i_y),
    .i_rgb       (i_rgb),
    .i_frame_end (i_frame_end),
    .o_left      (o_left),
    .o_right     (o_right),
    .o_up        (o_up),
    .o_down      (o_down),
    .o_count     (o_count),
    .o_valid     (o_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [87:0] co;
    logic [19:0] cnt;
    int          fe;
  } exp_t;

  exp_t sb[$];
  int applied = 0;
  int miscmp  = 0;

  localparam logic [87:0] ALL_NF = {8{NOT_FOUND}};

  function automatic logic [87:0] obs_c();
    return {o_left[0], o_left[1], o_right[0], o_right[1],
            o_up[0], o_up[1], o_down[0], o_down[1]};
  endfunction

  // Hand-derived results for each stimulus pattern (RUN_MIN=4).
  function automatic exp_t exp_for(input int mode);
    exp_t e;
    e.fe  = 0;
    e.co  = ALL_NF;
    e.cnt = 20'd0;
    case (mode)
      1, 5: begin
        e.co  = {11'd103, 11'd200, 11'd119, 11'd200,
                 11'd103, 11'd200, 11'd103, 11'd219};
        e.cnt = 20'd340;
      end
      2: e.cnt = 20'd10;
      4: begin
        e.co  = {11'd115, 11'd200, 11'd127, 11'd200,
                 11'd115, 11'd200, 11'd115, 11'd223};
        e.cnt = 20'd312;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit inbox(int x, int y, int x0, int x1, int y0, int y1);
    return x >= x0 && x <= x1 && y >= y0 && y <= y1;
  endfunction

  // Returns {R, G, B}.
  function automatic logic [23:0] colour(input int mode, input int x, input int y);
    logic [23:0] c;
    c = 24'h000000;
    case (mode)
      1: if (inbox(x, y, 100, 119, 200, 219)) c = 24'hFF0000;
      2: if (inbox(x, y, 100, 104, 200, 204)) c = 24'hFF0000;
      3: if (y == 200) begin
           if ((x >= 100 && x <= 102) || (x >= 104 && x <= 106)) c = 24'hFF0000;
           else if (x == 103) c = 24'h00FF00;
         end
      4: if (inbox(x, y, 112, 127, 200, 223)) c = 24'hFF0000;
      5: if (inbox(x, y, 100, 119, 200, 219)) c = {8'd160, 8'd90, 8'd90};
      6: if (inbox(x, y, 100, 119, 200, 219)) begin
           if (y % 3 == 0) c = {8'd159, 8'd0, 8'd0};
           else if (y % 3 == 1) c = {8'd255, 8'd91, 8'd0};
           else c = {8'd255, 8'd0, 8'd91};
         end
      default: ;
    endcase
    return c;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      #1;
      i_valid     = 1'b0;
      i_frame_end = 1'b0;
      i_rst       = 1'b0;
    end
  endtask

  // Raster window x 96..127, y 196..223; frame_end rides on the last pixel.
  task automatic drive_frame(input int mode, input bit pub, input int rst_at);
    int idx;
    logic [23:0] c;
    exp_t e;
    idx = 0;
    for (int y = 196; y <= 223; y++) begin
      for (int x = 96; x <= 127; x++) begin
        @(posedge i_clk);
        #1;
        c           = colour(mode, x, y);
        i_valid     = 1'b1;
        i_x         = coord_t'(x);
        i_y         = coord_t'(y);
        i_rgb[0]    = c[23:16];
        i_rgb[1]    = c[15:8];
        i_rgb[2]    = c[7:0];
        i_rst       = (idx == rst_at);
        i_frame_end = (x == 127 && y == 223);
        if (i_frame_end && pub) begin
          e    = exp_for(mode);
          e.fe = cyc;
          sb.push_back(e);
        end
        idx++;
      end
    end
  endtask

  task automatic wait_pub(input int budget, output bit got, output int pc);
    got = 1'b0;
    pc  = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        got = 1'b1;
        pc  = cyc;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    int pc;
    i_rst = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_frame_end = 1'b0;
    i_x = '0; i_y = '0;
    i_rgb[0] = '0; i_rgb[1] = '0; i_rgb[2] = '0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    applied++;
    if (obs_c() !== ALL_NF) begin
      miscmp++; $display("FAIL reset_coords got %h want %h", obs_c(), ALL_NF);
    end
    applied++;
    if (o_count !== 20'd0 || o_valid !== 1'b0) begin
      miscmp++; $display("FAIL reset_cnt got %0d/%b want 0/0", o_count, o_valid);
    end
    i_enable = 1'b1;
    drive_frame(0, 1'b0, -1);
    idle(1);
    wait_pub(12, got, pc);
    applied++;
    if (got !== 1'b0) begin
      miscmp++; $display("FAIL arm_no_publish got o_valid at %0d want none", pc);
    end
  endtask

  task automatic test_frames(input string nm, input int mode);
    bit got;
    int pc;
    exp_t e;
    drive_frame(mode, 1'b1, -1);
    idle(1);
    wait_pub(20, got, pc);
    applied++;
    if (!got || sb.size() == 0) begin
      miscmp++; $display("FAIL %s publish got o_valid=%b want 1", nm, got);
      sb.delete();
    end else begin
      e = sb.pop_front();
      applied++;
      if (pc - e.fe !== 3) begin
        miscmp++; $display("FAIL %s latency got %0d want 3", nm, pc - e.fe);
      end
      applied++;
      if (obs_c() !== e.co) begin
        miscmp++; $display("FAIL %s coords got %h want %h", nm, obs_c(), e.co);
      end
      applied++;
      if (o_count !== e.cnt) begin
        miscmp++; $display("FAIL %s count got %0d want %0d", nm, o_count, e.cnt);
      end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    bit got;
    int pc;
    exp_t e;
    fork
      begin
        drive_frame(1, 1'b1, -1);
        drive_frame(2, 1'b1, -1);
        idle(1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          wait_pub(2000, got, pc);
          applied++;
          if (!got || sb.size() == 0) begin
            miscmp++; $display("FAIL b2b_%0d publish got o_valid=%b want 1", k, got);
          end else begin
            e = sb.pop_front();
            applied++;
            if (pc - e.fe !== 3) begin
              miscmp++; $display("FAIL b2b_%0d latency got %0d want 3", k, pc - e.fe);
            end
            applied++;
            if (obs_c() !== e.co) begin
              miscmp++; $display("FAIL b2b_%0d coords got %h want %h", k, obs_c(), e.co);
            end
            applied++;
            if (o_count !== e.cnt) begin
              miscmp++; $display("FAIL b2b_%0d count got %0d want %0d", k, o_count, e.cnt);
            end
          end
        end
      end
    join
    sb.delete();
    idle(4);
  endtask

  task automatic test_mid_reset();
    bit got;
    int pc;
    drive_frame(1, 1'b0, 300);
    idle(1);
    wait_pub(12, got, pc);
    applied++;
    if (got !== 1'b0) begin
      miscmp++; $display("FAIL midrst_no_publish got o_valid at %0d want none", pc);
    end
    applied++;
    if (obs_c() !== ALL_NF || o_count !== 20'd0) begin
      miscmp++; $display("FAIL midrst_cleared got %h/%0d want %h/0", obs_c(), o_count, ALL_NF);
    end
    test_frames("midrst_next", 1);
  endtask

  initial begin
    test_reset();
    test_frames("empty", 0);
    test_frames("square", 1);
    test_frames("small", 2);
    test_frames("broken_run", 3);
    test_frames("thresh_edge", 5);
    test_frames("thresh_miss", 6);
    test_frames("fe_pixel", 4);
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule
